// File: rtl/rotenc_pkg.sv
// rotenc_pkg: shared types for the rotary encoder tracker.
// Optional build macro ROTENC_GRAY_EN selects Gray-coded encoder inputs.
package rotenc_pkg;

  // Per-channel debounce/commit state.
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_SETTLE = 2'd2
  } rot_state_e;

  // Classification of a committed move by its modular distance.
  typedef enum logic [1:0] {
    DC_NONE = 2'd0,
    DC_CW   = 2'd1,
    DC_CCW  = 2'd2,
    DC_SKIP = 2'd3
  } delta_cls_e;

  // Gray to binary on a zero-extended code; upper zero bits leave the
  // low bits unaffected, so callers truncate to their own width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/rotenc_chan.sv
// rotenc_chan: one encoder channel -- 2-FF sync, optional Gray decode
// (ROTENC_GRAY_EN), debounce FSM, step/dir/skip events, turn counter.
module rotenc_chan
  import rotenc_pkg::*;
#(
  parameter int CODE_W  = 4,
  parameter int DEB_CYC = 50000,
  parameter int TURN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_i,
  output logic [CODE_W-1:0] pos_o,
  output logic              valid_o,
  output logic              step_o,
  output logic              dir_o,
  output logic              skip_o,
  output logic [TURN_W-1:0] turns_o
);

  localparam int                CNT_W    = $clog2(DEB_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CODE_W-1:0] HALF     = CODE_W'(1 << (CODE_W - 1));

  logic [CODE_W-1:0] sync1_q, sync2_q, s;
  rot_state_e        state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] pos_q, pos_d;
  logic              valid_q, valid_d;
  logic              step_q, step_d;
  logic              dir_q, dir_d;
  logic              skip_q, skip_d;
  logic [TURN_W-1:0] turns_q, turns_d;
  logic              commit;
  logic [CODE_W-1:0] delta;
  delta_cls_e        cls;

`ifdef ROTENC_GRAY_EN
  assign s = CODE_W'(gray2bin(32'(sync2_q)));
`else
  assign s = sync2_q;
`endif

  // Next state: debounce the synchronised code, flag a commit when stable.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (s != cand_q) begin
          cand_d = s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (s != pos_q) begin
          cand_d  = s;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (s == pos_q) begin
          state_d = ST_STABLE;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Classify the pending move by modular distance from the committed position.
  always_comb begin
    delta = cand_q - pos_q;
    if (delta == '0)       cls = DC_NONE;
    else if (delta == HALF) cls = DC_SKIP;
    else if (delta < HALF)  cls = DC_CW;
    else                    cls = DC_CCW;
  end

  // Output next-state: first commit is silent, later commits raise events.
  always_comb begin
    pos_d   = pos_q;
    valid_d = valid_q;
    step_d  = 1'b0;
    skip_d  = 1'b0;
    dir_d   = dir_q;
    turns_d = turns_q;
    if (commit) begin
      pos_d   = cand_q;
      valid_d = 1'b1;
      if (state_q == ST_SETTLE) begin
        case (cls)
          DC_CW: begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            if (cand_q < pos_q) turns_d = turns_q + TURN_W'(1);
          end
          DC_CCW: begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            if (cand_q > pos_q) turns_d = turns_q - TURN_W'(1);
          end
          DC_SKIP: skip_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Register sync chain, FSM and outputs; reset discards any pending candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= ST_INIT;
      cand_q  <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      skip_q  <= 1'b0;
      turns_q <= '0;
    end else begin
      sync1_q <= code_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      skip_q  <= skip_d;
      turns_q <= turns_d;
    end
  end

  assign pos_o   = pos_q;
  assign valid_o = valid_q;
  assign step_o  = step_q;
  assign dir_o   = dir_q;
  assign skip_o  = skip_q;
  assign turns_o = turns_q;

endmodule

// File: rtl/rotenc_track.sv
// rotenc_track: NCH independent absolute-encoder trackers.
// Build with ROTENC_GRAY_EN for Gray-coded encoder inputs.
module rotenc_track
  import rotenc_pkg::*;
#(
  parameter int NCH     = 1,
  parameter int CODE_W  = 4,
  parameter int DEB_CYC = 50000,
  parameter int TURN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*CODE_W-1:0] prrot,
  output logic [NCH*CODE_W-1:0] pos,
  output logic [NCH-1:0]        valid,
  output logic [NCH-1:0]        step,
  output logic [NCH-1:0]        dir,
  output logic [NCH-1:0]        skip,
  output logic [NCH*TURN_W-1:0] turns
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    rotenc_chan #(
      .CODE_W (CODE_W),
      .DEB_CYC(DEB_CYC),
      .TURN_W (TURN_W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .code_i (prrot[c*CODE_W +: CODE_W]),
      .pos_o  (pos[c*CODE_W +: CODE_W]),
      .valid_o(valid[c]),
      .step_o (step[c]),
      .dir_o  (dir[c]),
      .skip_o (skip[c]),
      .turns_o(turns[c*TURN_W +: TURN_W])
    );
  end

endmodule

// File: tb/tb_rotenc_track.sv
// Directed bench for rotenc_track: NCH=2, CODE_W=4, DEB_CYC=4, TURN_W=8.
module tb_rotenc_track;

  localparam int NCH = 2, CODE_W = 4, DEB_CYC = 4, TURN_W = 8;
  localparam int LAT = 3 + DEB_CYC;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH*CODE_W-1:0] prrot = '0;
  logic [NCH*CODE_W-1:0] pos;
  logic [NCH-1:0]        valid, step, dir, skip;
  logic [NCH*TURN_W-1:0] turns;

  int nvec = 0, nerr = 0;
  int step_n[NCH];
  int skip_n[NCH];
  int bs0, bk0, bs1, bk1;

  rotenc_track #(.NCH(NCH), .CODE_W(CODE_W), .DEB_CYC(DEB_CYC), .TURN_W(TURN_W)) dut (
    .clk(clk), .rst(rst), .prrot(prrot), .pos(pos), .valid(valid),
    .step(step), .dir(dir), .skip(skip), .turns(turns)
  );

  always #5 clk = ~clk;

  initial begin
    for (int c = 0; c < NCH; c++) begin step_n[c] = 0; skip_n[c] = 0; end
  end

  // Pulse counters, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < NCH; c++) begin
      if (step[c] === 1'b1) step_n[c]++;
      if (skip[c] === 1'b1) skip_n[c]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [3:0] v);
    prrot[ch*CODE_W +: CODE_W] = v;
  endtask

  task automatic do_move(input int ch, input logic [3:0] v);
    set_ch(ch, v);
    tick(LAT + 1);
  endtask

  task automatic snap();
    bs0 = step_n[0]; bk0 = skip_n[0]; bs1 = step_n[1]; bk1 = skip_n[1];
  endtask

  task automatic test_reset();
    set_ch(0, 4'd5); set_ch(1, 4'd2);
    tick(3);
    nvec++; if (pos !== 8'h00) begin nerr++; $display("FAIL reset_pos: got %h expected 00", pos); end
    nvec++; if (valid !== 2'b00) begin nerr++; $display("FAIL reset_valid: got %b expected 00", valid); end
    nvec++; if (step !== 2'b00) begin nerr++; $display("FAIL reset_step: got %b expected 00", step); end
    nvec++; if (skip !== 2'b00) begin nerr++; $display("FAIL reset_skip: got %b expected 00", skip); end
    nvec++; if (dir !== 2'b00) begin nerr++; $display("FAIL reset_dir: got %b expected 00", dir); end
    nvec++; if (turns !== 16'h0000) begin nerr++; $display("FAIL reset_turns: got %h expected 0000", turns); end
  endtask

  task automatic test_init_commit();
    rst = 1'b0;
    snap();
    tick(LAT - 1);
    nvec++; if (valid !== 2'b00) begin nerr++; $display("FAIL init_early_valid: got %b expected 00", valid); end
    tick(1);
    nvec++; if (pos !== 8'h25) begin nerr++; $display("FAIL init_pos: got %h expected 25", pos); end
    nvec++; if (valid !== 2'b11) begin nerr++; $display("FAIL init_valid: got %b expected 11", valid); end
    tick(2);
    nvec++; if ((step_n[0] - bs0) + (step_n[1] - bs1) !== 0)
      begin nerr++; $display("FAIL init_no_step: got %0d expected 0", (step_n[0]-bs0)+(step_n[1]-bs1)); end
    nvec++; if ((skip_n[0] - bk0) + (skip_n[1] - bk1) !== 0)
      begin nerr++; $display("FAIL init_no_skip: got %0d expected 0", (skip_n[0]-bk0)+(skip_n[1]-bk1)); end
  endtask

  task automatic test_cw();
    snap();
    set_ch(0, 4'd6);
    tick(LAT - 1);
    nvec++; if (pos[3:0] !== 4'd5) begin nerr++; $display("FAIL cw_early_pos: got %0d expected 5", pos[3:0]); end
    tick(1);
    nvec++; if (pos[3:0] !== 4'd6) begin nerr++; $display("FAIL cw_pos: got %0d expected 6", pos[3:0]); end
    nvec++; if (step[0] !== 1'b1) begin nerr++; $display("FAIL cw_step: got %b expected 1", step[0]); end
    nvec++; if (dir[0] !== 1'b1) begin nerr++; $display("FAIL cw_dir: got %b expected 1", dir[0]); end
    nvec++; if (turns[7:0] !== 8'd0) begin nerr++; $display("FAIL cw_turns: got %0d expected 0", turns[7:0]); end
    tick(3);
    nvec++; if (step_n[0] - bs0 !== 1) begin nerr++; $display("FAIL cw_pulses: got %0d expected 1", step_n[0]-bs0); end
    nvec++; if (skip_n[0] - bk0 !== 0) begin nerr++; $display("FAIL cw_skip: got %0d expected 0", skip_n[0]-bk0); end
  endtask

  task automatic test_wrap();
    do_move(0, 4'd10);
    do_move(0, 4'd15);
    nvec++; if (turns[7:0] !== 8'd0) begin nerr++; $display("FAIL wrap_pre_turns: got %0d expected 0", turns[7:0]); end
    snap();
    set_ch(0, 4'd0);
    tick(LAT);
    nvec++; if (pos[3:0] !== 4'd0) begin nerr++; $display("FAIL wrap_up_pos: got %0d expected 0", pos[3:0]); end
    nvec++; if (dir[0] !== 1'b1) begin nerr++; $display("FAIL wrap_up_dir: got %b expected 1", dir[0]); end
    nvec++; if (turns[7:0] !== 8'd1) begin nerr++; $display("FAIL wrap_up_turns: got %0d expected 1", turns[7:0]); end
    tick(1);
    set_ch(0, 4'd15);
    tick(LAT);
    nvec++; if (pos[3:0] !== 4'd15) begin nerr++; $display("FAIL wrap_dn_pos: got %0d expected 15", pos[3:0]); end
    nvec++; if (dir[0] !== 1'b0) begin nerr++; $display("FAIL wrap_dn_dir: got %b expected 0", dir[0]); end
    nvec++; if (turns[7:0] !== 8'd0) begin nerr++; $display("FAIL wrap_dn_turns: got %0d expected 0", turns[7:0]); end
    tick(2);
    nvec++; if (step_n[0] - bs0 !== 2) begin nerr++; $display("FAIL wrap_pulses: got %0d expected 2", step_n[0]-bs0); end
  endtask

  task automatic test_bounce();
    do_move(0, 4'd8);   // 15->8 CCW, no wrap
    do_move(0, 4'd6);   // 8->6 CCW
    snap();
    set_ch(0, 4'd7);
    tick(2);
    set_ch(0, 4'd6);
    tick(12);
    nvec++; if (pos[3:0] !== 4'd6) begin nerr++; $display("FAIL bounce_pos: got %0d expected 6", pos[3:0]); end
    nvec++; if (step_n[0] - bs0 !== 0) begin nerr++; $display("FAIL bounce_step: got %0d expected 0", step_n[0]-bs0); end
    nvec++; if (skip_n[0] - bk0 !== 0) begin nerr++; $display("FAIL bounce_skip: got %0d expected 0", skip_n[0]-bk0); end
    nvec++; if (dir[0] !== 1'b0) begin nerr++; $display("FAIL bounce_dir: got %b expected 0", dir[0]); end
    // A following clean move must commit with normal latency from STABLE.
    set_ch(0, 4'd2);
    tick(LAT - 1);
    nvec++; if (pos[3:0] !== 4'd6) begin nerr++; $display("FAIL post_bounce_early: got %0d expected 6", pos[3:0]); end
    tick(1);
    nvec++; if (pos[3:0] !== 4'd2) begin nerr++; $display("FAIL post_bounce_pos: got %0d expected 2", pos[3:0]); end
    nvec++; if (step[0] !== 1'b1) begin nerr++; $display("FAIL post_bounce_step: got %b expected 1", step[0]); end
    tick(1);
  endtask

  task automatic test_skip();
    do_move(0, 4'd3);   // 2->3 CW sets dir=1
    nvec++; if (dir[0] !== 1'b1) begin nerr++; $display("FAIL skip_pre_dir: got %b expected 1", dir[0]); end
    snap();
    set_ch(0, 4'd11);
    tick(LAT);
    nvec++; if (skip[0] !== 1'b1) begin nerr++; $display("FAIL skip_pulse: got %b expected 1", skip[0]); end
    nvec++; if (step[0] !== 1'b0) begin nerr++; $display("FAIL skip_step: got %b expected 0", step[0]); end
    nvec++; if (pos[3:0] !== 4'd11) begin nerr++; $display("FAIL skip_pos: got %0d expected 11", pos[3:0]); end
    nvec++; if (dir[0] !== 1'b1) begin nerr++; $display("FAIL skip_dir: got %b expected 1", dir[0]); end
    nvec++; if (turns[7:0] !== 8'd0) begin nerr++; $display("FAIL skip_turns: got %0d expected 0", turns[7:0]); end
    tick(3);
    nvec++; if (skip_n[0] - bk0 !== 1) begin nerr++; $display("FAIL skip_count: got %0d expected 1", skip_n[0]-bk0); end
    nvec++; if (step_n[0] - bs0 !== 0) begin nerr++; $display("FAIL skip_steps: got %0d expected 0", step_n[0]-bs0); end
  endtask

  task automatic test_reset_mid();
    nvec++; if (pos !== 8'h2B) begin nerr++; $display("FAIL mid_pre_pos: got %h expected 2b", pos); end
    set_ch(1, 4'd1);
    tick(4);
    nvec++; if (pos[7:4] !== 4'd2) begin nerr++; $display("FAIL mid_settle_pos1: got %0d expected 2", pos[7:4]); end
    nvec++; if (pos[3:0] !== 4'd11) begin nerr++; $display("FAIL mid_ch0_pos: got %0d expected 11", pos[3:0]); end
    rst = 1'b1;
    tick(1);
    nvec++; if (pos !== 8'h00) begin nerr++; $display("FAIL mid_rst_pos: got %h expected 00", pos); end
    nvec++; if (valid !== 2'b00) begin nerr++; $display("FAIL mid_rst_valid: got %b expected 00", valid); end
    nvec++; if (dir !== 2'b00) begin nerr++; $display("FAIL mid_rst_dir: got %b expected 00", dir); end
    nvec++; if (turns !== 16'h0000) begin nerr++; $display("FAIL mid_rst_turns: got %h expected 0000", turns); end
    nvec++; if ((step | skip) !== 2'b00) begin nerr++; $display("FAIL mid_rst_events: got %b expected 00", step | skip); end
    tick(1);
    rst = 1'b0;
    snap();
    tick(LAT - 1);
    nvec++; if (valid[1] !== 1'b0) begin nerr++; $display("FAIL mid_early_valid1: got %b expected 0", valid[1]); end
    tick(1);
    nvec++; if (pos !== 8'h1B) begin nerr++; $display("FAIL mid_commit_pos: got %h expected 1b", pos); end
    nvec++; if (valid !== 2'b11) begin nerr++; $display("FAIL mid_commit_valid: got %b expected 11", valid); end
    tick(2);
    nvec++; if (step_n[1] - bs1 !== 0) begin nerr++; $display("FAIL mid_no_step1: got %0d expected 0", step_n[1]-bs1); end
    nvec++; if (skip_n[1] - bk1 !== 0) begin nerr++; $display("FAIL mid_no_skip1: got %0d expected 0", skip_n[1]-bk1); end
  endtask

  initial begin
    test_reset();
    test_init_commit();
    test_cw();
    test_wrap();
    test_bounce();
    test_skip();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
